piso_sr: RTL and testbench

- Parallel-in/serial-out shift register: the transmit-side counterpart of the team's `sipo_sr` deserializer.
- Accepts a WIDTH-bit word through a valid/ready handshake and emits it one bit per clock on `so`.
- Provides framing strobes (`so_valid`, `so_first`, `so_last`) so a downstream `sipo_sr` or a checker can align on word boundaries.
- Supports back-to-back words with no idle gap, and a `hold` input that stalls the serial stream.

---
 rtl/piso_sr.sv | 135 +++++++++++++
 tb/tb_piso_sr.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/piso_sr.sv
// piso_sr -- parallel-in / serial-out shift register with framing strobes.
//
// Takes a WIDTH-bit word through a valid/ready handshake and sends it one
// bit per clock on so. so_first and so_last mark word boundaries so a
// downstream deserializer can stay aligned. A new word can be accepted on
// the edge that retires the last bit, which keeps words streaming back to
// back with no idle gap. hold stalls the serial stream while shifting.
//
// Ports
//   clk       system clock, rising edge
//   clear     asynchronous active-high reset
//   pi        parallel word, sampled only on an accept edge
//   in_valid  pi holds a valid word
//   in_ready  a word can be accepted this cycle (combinational)
//   hold      freezes the serial stream while shifting
//   so        serial data out (flop output)
//   so_valid  so carries a data bit
//   so_first  so carries the first bit of a word
//   so_last   so carries the last bit of a word
//   busy      a word is being shifted out
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no word in flight; so and strobes low; ready for a word
// ST_SHIFT | sr_q holds the remaining bits, cnt_q indexes the bit on so

module piso_sr #(
   parameter int WIDTH     = 4,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             clear,
   input  logic [WIDTH-1:0] pi,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             hold,
   output logic             so,
   output logic             so_valid,
   output logic             so_first,
   output logic             so_last,
   output logic             busy
);

   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             shifting;
   logic             at_last;
   logic             accept;
   logic [WIDTH-1:0] sr_adv;

   // The bit currently on so always sits at the transmit end of sr_q, so so
   // comes straight from a flop; advancing pushes zeros in at the far end.
   generate
      if (MSB_FIRST != 0) begin : g_msb_first
         assign sr_adv = {sr_q[WIDTH-2:0], 1'b0};
         assign so     = sr_q[WIDTH-1];
      end else begin : g_lsb_first
         assign sr_adv = {1'b0, sr_q[WIDTH-1:1]};
         assign so     = sr_q[0];
      end
   endgenerate

   assign shifting = (state_q == ST_SHIFT);
   assign at_last  = shifting && (cnt_q == CNT_LAST);

   // Ready in IDLE regardless of hold; while shifting only on the edge that
   // retires the last bit, which is what makes zero-gap streaming possible.
   assign in_ready = !shifting || (at_last && !hold);
   assign accept   = in_valid && in_ready;

   assign so_valid = shifting;
   assign so_first = shifting && (cnt_q == '0);
   assign so_last  = at_last;
   assign busy     = shifting;

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_SHIFT;
               sr_d    = pi;
               cnt_d   = '0;
            end
         end
         ST_SHIFT: begin
            if (!hold) begin
               if (cnt_q == CNT_LAST) begin
                  if (accept) begin
                     sr_d  = pi;
                     cnt_d = '0;
                  end else begin
                     state_d = ST_IDLE;
                     sr_d    = '0;
                     cnt_d   = '0;
                  end
               end else begin
                  sr_d  = sr_adv;
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            sr_d    = '0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state_q <= ST_IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_piso_sr.sv
// Bench for piso_sr, WIDTH=4. Two instances share one stimulus: index 0 sends
// MSB first, index 1 sends LSB first. A word-level model (current word, bit
// index, active flag) predicts every output each cycle; directed vectors
// with literal expectations pin the model.

module tb_piso_sr;

   localparam int W = 4;

   logic         clk;
   logic         clear;
   logic [W-1:0] pi;
   logic         in_valid;
   logic         hold;
   logic [1:0]   in_ready_o, so_o, so_valid_o, so_first_o, so_last_o, busy_o;

   int checks = 0;
   int errors = 0;
   bit run_cmp = 1'b0;

   piso_sr #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
      .clk(clk), .clear(clear), .pi(pi), .in_valid(in_valid),
      .in_ready(in_ready_o[0]), .hold(hold), .so(so_o[0]),
      .so_valid(so_valid_o[0]), .so_first(so_first_o[0]),
      .so_last(so_last_o[0]), .busy(busy_o[0])
   );

   piso_sr #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
      .clk(clk), .clear(clear), .pi(pi), .in_valid(in_valid),
      .in_ready(in_ready_o[1]), .hold(hold), .so(so_o[1]),
      .so_valid(so_valid_o[1]), .so_first(so_first_o[1]),
      .so_last(so_last_o[1]), .busy(busy_o[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", nm, got, exp);
      end
   endtask

   // ---------------- model ----------------
   logic [W-1:0] m_word [2];
   int           m_k    [2];
   bit           m_act  [2];

   function automatic bit m_rdy(input int d);
      return !m_act[d] || (m_k[d] == W - 1 && !hold);
   endfunction

   function automatic logic m_so(input int d);
      if (!m_act[d]) return 1'b0;
      return (d == 0) ? m_word[d][W-1-m_k[d]] : m_word[d][m_k[d]];
   endfunction

   always @(posedge clk or posedge clear) begin
      bit acc;
      for (int d = 0; d < 2; d++) begin
         if (clear) begin
            m_act[d]  = 1'b0;
            m_k[d]    = 0;
            m_word[d] = '0;
         end else begin
            acc = in_valid && m_rdy(d);
            if (m_act[d] && !hold) begin
               if (m_k[d] == W - 1) m_act[d] = 1'b0;
               else                 m_k[d]   = m_k[d] + 1;
            end
            if (acc) begin
               m_word[d] = pi;
               m_k[d]    = 0;
               m_act[d]  = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (run_cmp && !clear) begin
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("model d%0d so", d),       so_o[d],       m_so(d));
            chk($sformatf("model d%0d so_valid", d), so_valid_o[d], m_act[d]);
            chk($sformatf("model d%0d so_first", d), so_first_o[d], m_act[d] && m_k[d] == 0);
            chk($sformatf("model d%0d so_last", d),  so_last_o[d],  m_act[d] && m_k[d] == W - 1);
            chk($sformatf("model d%0d busy", d),     busy_o[d],     m_act[d]);
            chk($sformatf("model d%0d in_ready", d), in_ready_o[d], m_rdy(d));
         end
      end
   end

   // ---------------- directed vectors ----------------
   function automatic logic cb(input string s, input int i);
      return (s.getc(i) == "1");
   endfunction

   // Called just after a rising edge. Character i of each string is cycle i.
   task automatic vec(input string nm, input int d, input string iv, input string hd,
                      input logic [W-1:0] w0, input logic [W-1:0] w1, input int sw,
                      input string e_so, input string e_v, input string e_f,
                      input string e_l, input string e_r,
                      input bit chk_po, input logic [W-1:0] e_po);
      logic [W-1:0] po;
      po = '0;
      for (int i = 0; i < e_so.len(); i++) begin
         in_valid = cb(iv, i);
         hold     = cb(hd, i);
         pi       = (i < sw) ? w0 : w1;
         @(negedge clk);
         chk($sformatf("%s c%0d so", nm, i),       so_o[d],       cb(e_so, i));
         chk($sformatf("%s c%0d so_valid", nm, i), so_valid_o[d], cb(e_v, i));
         chk($sformatf("%s c%0d so_first", nm, i), so_first_o[d], cb(e_f, i));
         chk($sformatf("%s c%0d so_last", nm, i),  so_last_o[d],  cb(e_l, i));
         chk($sformatf("%s c%0d busy", nm, i),     busy_o[d],     cb(e_v, i));
         chk($sformatf("%s c%0d in_ready", nm, i), in_ready_o[d], cb(e_r, i));
         if (so_valid_o[d])
            po = (d == 0) ? {po[W-2:0], so_o[d]} : {so_o[d], po[W-1:1]};
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      hold     = 1'b0;
      if (chk_po) chk({nm, " loopback po"}, po, e_po);
   endtask

   initial begin
      clear    = 1'b1;
      pi       = '0;
      in_valid = 1'b0;
      hold     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("reset d%0d so", d),       so_o[d],       1'b0);
         chk($sformatf("reset d%0d so_valid", d), so_valid_o[d], 1'b0);
         chk($sformatf("reset d%0d busy", d),     busy_o[d],     1'b0);
         chk($sformatf("reset d%0d in_ready", d), in_ready_o[d], 1'b1);
      end
      clear   = 1'b0;
      run_cmp = 1'b1;

      // async clear mid-transfer, between edges, while so_valid=1
      in_valid = 1'b1;
      pi       = 4'b1001;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("midxfer so_valid", so_valid_o[0], 1'b1);
      #2;
      clear = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("async clr d%0d so", d),       so_o[d],       1'b0);
         chk($sformatf("async clr d%0d so_valid", d), so_valid_o[d], 1'b0);
         chk($sformatf("async clr d%0d busy", d),     busy_o[d],     1'b0);
         chk($sformatf("async clr d%0d in_ready", d), in_ready_o[d], 1'b1);
      end
      #1;
      clear = 1'b0;
      @(posedge clk);
      #1;

      // single word MSB first (also the word sent after the clear)
      vec("single", 0, "100000", "000000", 4'b1001, 4'b1001, 1,
          "010010", "011110", "010000", "000010", "100011", 1'b1, 4'b1001);

      // back-to-back, second word held on in_valid until the last-bit edge
      vec("b2b", 0, "1111100000", "0000000000", 4'b1001, 4'b0110, 1,
          "0100101100", "0111111110", "0100010000", "0000100010", "1000100011",
          1'b0, 4'b0000);

      // hold for two cycles on bit 2
      vec("hold", 0, "10000000", "00011000", 4'b1010, 4'b1010, 1,
          "01011100", "01111110", "01000000", "00000010", "10000011",
          1'b0, 4'b0000);

      // LSB first with loopback into an LSB-first deserializer
      vec("lsb", 1, "100000", "000000", 4'b0010, 4'b0010, 1,
          "001000", "011110", "010000", "000010", "100011", 1'b1, 4'b0010);

      // hold asserted in IDLE does not block the accept
      vec("idlehold", 0, "1000000", "1100000", 4'b1111, 4'b1111, 1,
          "0111110", "0111110", "0110000", "0000010", "1000011",
          1'b0, 4'b0000);

      repeat (2) @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
